// File: rtl/alu_pkg.sv
// alu_pkg: shared operation codes, default width and FSM state type for the sequential ALU.
// Build option: define ALU_SEQ_FAST_SHIFT_EN for single-cycle barrel shifts.
package alu_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_XOR = 4'b0110,
        OP_SRA = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_BNE = 4'b1001,
        OP_BLT = 4'b1010,
        OP_SLT = 4'b1100
    } op_e;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
`ifdef ALU_SEQ_FAST_SHIFT_EN
    localparam bit FAST_SHIFT = 1'b1;
`else
    localparam bit FAST_SHIFT = 1'b0;
`endif
endpackage

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: shifter, one bit per step by default or a combinational barrel shift with ALU_SEQ_FAST_SHIFT_EN.
// Ports: load captures data_in/shamt/dir/arith; step shifts one bit; dir 0=left 1=right;
// arith replicates the MSB on right shifts; sh_out is the value after the current step; done flags the last step.
module alu_shift_unit #(
    parameter int DW = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic          dir,
    input  logic          arith,
    input  logic [DW-1:0] data_in,
    input  logic [SW-1:0] shamt,
    output logic [DW-1:0] sh_out,
    output logic          done
);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    logic signed [DW-1:0] sra_v;
    assign sra_v  = $signed(data_in) >>> shamt;
    assign sh_out = !dir ? data_in << shamt : arith ? sra_v : data_in >> shamt;
    assign done   = 1'b1;
`else
    logic [DW-1:0] val;
    logic [SW-1:0] cnt;
    logic          dir_q;
    logic          arith_q;
    // cnt starts at shamt-1 so done marks the step that produces the final value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val     <= '0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            val     <= data_in;
            cnt     <= shamt - SW'(1);
            dir_q   <= dir;
            arith_q <= arith;
        end else if (step) begin
            val <= sh_out;
            cnt <= cnt - SW'(1);
        end
    end
    assign sh_out = !dir_q ? {val[DW-2:0], 1'b0} : {arith_q & val[DW-1], val[DW-1:1]};
    assign done   = cnt == '0;
`endif
endmodule

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: handshaked ALU with registered result; shifts iterate in alu_shift_unit unless ALU_SEQ_FAST_SHIFT_EN.
// Ports: clk, rst_n (sync active-low); in_valid/in_ready request handshake with Operation, SrcA, SrcB;
// out_valid/out_ready result handshake with ALUResult and Zero held stable while out_valid.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);
    state_e                  state, nxt;
    logic                    accept, is_shift, go_shift, load, step, sh_done, zero_c;
    logic [SHAMT_WIDTH-1:0]  shamt;
    logic [DATA_WIDTH-1:0]   res_c, sh_out;

    assign in_ready  = state == IDLE && rst_n;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign shamt     = SrcB[SHAMT_WIDTH-1:0];
    assign is_shift  = Operation inside {OP_SLL, OP_SRL, OP_SRA};
    // a zero shift amount finishes immediately with SrcA, so only k>0 needs the SHIFT state
    assign go_shift  = is_shift && shamt != '0 && !FAST_SHIFT;

    alu_shift_unit #(.DW(DATA_WIDTH), .SW(SHAMT_WIDTH)) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .dir     (Operation != OP_SLL),
        .arith   (Operation == OP_SRA),
        .data_in (SrcA),
        .shamt   (shamt),
        .sh_out  (sh_out),
        .done    (sh_done)
    );

    always_comb begin
        res_c = '0;
        case (Operation)
            OP_AND:                 res_c = SrcA & SrcB;
            OP_OR:                  res_c = SrcA | SrcB;
            OP_ADD:                 res_c = SrcA + SrcB;
            OP_SUB:                 res_c = SrcA - SrcB;
            OP_XOR:                 res_c = SrcA ^ SrcB;
            OP_SLL, OP_SRL, OP_SRA: res_c = shamt == '0 ? SrcA : sh_out;
            OP_SLT:                 res_c = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
            default:                res_c = '0;
        endcase
        zero_c = Operation == OP_BEQ ? SrcA == SrcB :
                 Operation == OP_BNE ? SrcA != SrcB :
                 Operation == OP_BLT ? $signed(SrcA) < $signed(SrcB) :
                 Operation inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_XOR, OP_SRA, OP_SLT} ? res_c == '0 : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt  = state;
        load = 1'b0;
        step = 1'b0;
        case (state)
            IDLE: begin
                load = accept && go_shift;
                if (accept) nxt = go_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                step = 1'b1;
                if (sh_done) nxt = DONE;
            end
            DONE:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ALUResult <= '0;
            Zero      <= 1'b0;
        end else if (state == IDLE && accept && !go_shift) begin
            ALUResult <= res_c;
            Zero      <= zero_c;
        end else if (state == SHIFT && sh_done) begin
            ALUResult <= sh_out;
            Zero      <= sh_out == '0;
        end
    end
endmodule
